// File: rtl/mem_bus_fabric.sv
// Single-master memory-bus fabric: registered address decode, one-hot slave select and
// per-slave ready handshake. Optional watchdog on unresponsive slaves via BUS_TIMEOUT_EN.
module mem_bus_fabric #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned WINDOW_BITS    = 7,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             m_req_i,
  input  logic                             m_we_i,
  input  logic [ADDR_WIDTH-1:0]            m_addr_i,
  input  logic [DATA_WIDTH-1:0]            m_wdata_i,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic                             m_ready_o,
  output logic                             m_err_o,
  output logic                             m_busy_o,
  output logic [NUM_SLAVES-1:0]            s_sel_o,
  output logic                             s_we_o,
  output logic [WINDOW_BITS-1:0]           s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]            s_ready_i
);

  localparam int unsigned IdxW   = $clog2(NUM_SLAVES);
  localparam int unsigned TagLsb = WINDOW_BITS + IdxW;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  if (NUM_SLAVES < 2 || (NUM_SLAVES & (NUM_SLAVES - 1)) != 0 || TIMEOUT_CYCLES == 0)
  begin : g_param_check
    $error("mem_bus_fabric: bad NUM_SLAVES or TIMEOUT_CYCLES");
  end

  logic [1:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] s_sel_q, s_sel_d;
  logic                  s_we_q, s_we_d;
  logic [WINDOW_BITS-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
  logic                  m_ready_q, m_ready_d;
  logic                  m_err_q, m_err_d;
  logic                  m_busy_q, m_busy_d;

  logic [IdxW-1:0]       idx;
  logic                  hit;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign idx       = m_addr_i[WINDOW_BITS +: IdxW];
  assign hit       = (m_addr_i[ADDR_WIDTH-1:TagLsb] == BASE_ADDR[ADDR_WIDTH-1:TagLsb]);
  assign sel_ready = |(s_sel_q & s_ready_i);

  // s_sel_q is one-hot (or zero), so an OR-mux picks the selected slave's data
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel_q[i]) sel_rdata = sel_rdata | s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    s_sel_d   = s_sel_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_ready_d = 1'b0;
    m_err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (m_req_i) begin
          s_we_d    = m_we_i;
          s_addr_d  = m_addr_i[WINDOW_BITS-1:0];
          s_wdata_d = m_wdata_i;
          if (hit) begin
            s_sel_d      = '0;
            s_sel_d[idx] = 1'b1;
            state_d      = StAccess;
`ifdef BUS_TIMEOUT_EN
            cnt_d        = '0;
`endif
          end else begin
            s_sel_d   = '0;
            m_rdata_d = '0;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StAccess: begin
        if (sel_ready) begin
          m_rdata_d = s_we_q ? '0 : sel_rdata;
          s_sel_d   = '0;
          m_ready_d = 1'b1;
          state_d   = StResp;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Limit reached in this cycle with no ready: abandon the slave
          m_rdata_d = '0;
          s_sel_d   = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp:  state_d = StIdle;
      default: begin
        state_d = StIdle;
        s_sel_d = '0;
      end
    endcase
    m_busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_busy_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      s_sel_q   <= s_sel_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_rdata_q <= m_rdata_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      m_busy_q  <= m_busy_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign m_rdata_o = m_rdata_q;
  assign m_ready_o = m_ready_q;
  assign m_err_o   = m_err_q;
  assign m_busy_o  = m_busy_q;
  assign s_sel_o   = s_sel_q;
  assign s_we_o    = s_we_q;
  assign s_addr_o  = s_addr_q;
  assign s_wdata_o = s_wdata_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric: zero-wait read, wait-state write, decode miss,
// unresponsive slave (watchdog when BUS_TIMEOUT_EN is defined) and reset mid-access.
module tb_mem_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;
  logic         m_busy;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [6:0]   s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_fabric dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m_req_i   (m_req),
    .m_we_i    (m_we),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_rdata_o (m_rdata),
    .m_ready_o (m_ready),
    .m_err_o   (m_err),
    .m_busy_o  (m_busy),
    .s_sel_o   (s_sel),
    .s_we_o    (s_we),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_rdata_i (s_rdata),
    .s_ready_i (s_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic ok;
    rst     = 1'b1;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    s_ready = '0;
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hA5A5_0001, 32'hDEAD_BEEF};
    tick();
    tick();
    check("rst_sel",   64'(s_sel), 64'h0);
    check("rst_busy",  64'(m_busy), 64'h0);
    check("rst_ready", 64'(m_ready), 64'h0);
    check("rst_err",   64'(m_err), 64'h0);
    check("rst_rdata", 64'(m_rdata), 64'h0);
    check("rst_sout",  64'({s_we, s_addr, s_wdata}), 64'h0);
    rst = 1'b0;
    tick();

    // Zero-wait read from slave 0
    s_ready = 4'b0001;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0004;
    tick();
    m_req = 1'b0;
    check("zw_sel",   64'(s_sel), 64'h1);
    check("zw_addr",  64'(s_addr), 64'h04);
    check("zw_busy",  64'(m_busy), 64'h1);
    check("zw_early", 64'(m_ready), 64'h0);
    tick();
    check("zw_ready", 64'(m_ready), 64'h1);
    check("zw_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    check("zw_err",   64'(m_err), 64'h0);
    check("zw_selclr", 64'(s_sel), 64'h0);
    tick();
    check("zw_pulse", 64'(m_ready), 64'h0);
    check("zw_idle",  64'(m_busy), 64'h0);
    check("zw_hold",  64'(m_rdata), 64'hDEAD_BEEF);

    // Wait-state write to slave 3; other slaves' ready must be ignored
    s_ready = 4'b0111;
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h1001_0180; m_wdata = 32'h1234_5678;
    tick();
    m_req = 1'b0; m_wdata = 32'hFFFF_FFFF;
    check("ws_sel0", 64'(s_sel), 64'h8);
    check("ws_we",   64'(s_we), 64'h1);
    check("ws_addr", 64'(s_addr), 64'h00);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ok &= (s_sel === 4'b1000) && (s_wdata === 32'h1234_5678) && (m_ready === 1'b0);
    end
    check("ws_hold", 64'(ok), 64'h1);
    s_ready = 4'b1000;
    tick();
    s_ready = 4'b0000;
    check("ws_ready", 64'(m_ready), 64'h1);
    check("ws_err",   64'(m_err), 64'h0);
    check("ws_rdata", 64'(m_rdata), 64'h0);
    check("ws_selclr", 64'(s_sel), 64'h0);
    tick();
    check("ws_pulse", 64'(m_ready), 64'h0);

    // Decode miss
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h2000_0000;
    tick();
    m_req = 1'b0;
    check("miss_sel",   64'(s_sel), 64'h0);
    check("miss_ready", 64'(m_ready), 64'h1);
    check("miss_err",   64'(m_err), 64'h1);
    check("miss_rdata", 64'(m_rdata), 64'h0);
    tick();
    check("miss_pulse", 64'(m_ready), 64'h0);
    check("miss_idle",  64'(m_busy), 64'h0);

`ifdef BUS_TIMEOUT_EN
    // Slave 2 never ready: 16 ACCESS cycles, then error response
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0100;
    tick();
    m_req = 1'b0;
    ok = (s_sel === 4'b0100);
    for (int i = 0; i < 15; i++) begin
      tick();
      ok &= (s_sel === 4'b0100) && (m_ready === 1'b0);
    end
    check("to_hold", 64'(ok), 64'h1);
    tick();
    check("to_ready", 64'(m_ready), 64'h1);
    check("to_err",   64'(m_err), 64'h1);
    check("to_rdata", 64'(m_rdata), 64'h0);
    tick();

    // Ready arrives on the 16th ACCESS cycle: normal completion
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0100;
    tick();
    m_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    s_ready = 4'b0100;
    tick();
    s_ready = 4'b0000;
    check("race_ready", 64'(m_ready), 64'h1);
    check("race_err",   64'(m_err), 64'h0);
    check("race_rdata", 64'(m_rdata), 64'h2222_2222);
    tick();
`endif

    // Slave 2 silent; without the watchdog the fabric stays busy indefinitely
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0100;
    tick();
    m_req = 1'b0;
    check("stall_sel", 64'(s_sel), 64'h4);
`ifndef BUS_TIMEOUT_EN
    ok = 1'b1;
    for (int i = 0; i < 110; i++) begin
      tick();
      ok &= (m_busy === 1'b1) && (m_ready === 1'b0) && (s_sel === 4'b0100);
    end
    check("stall_busy", 64'(ok), 64'h1);
`else
    for (int i = 0; i < 4; i++) tick();
`endif

    // Reset during wait states
    rst = 1'b1;
    tick();
    check("rst_mid_sel",   64'(s_sel), 64'h0);
    check("rst_mid_busy",  64'(m_busy), 64'h0);
    check("rst_mid_ready", 64'(m_ready), 64'h0);
    rst = 1'b0;
    tick();
    check("rst_mid_nopulse", 64'(m_ready), 64'h0);

    // Zero-wait read from slave 1 after reset
    s_ready = 4'b0010;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0088;
    tick();
    m_req = 1'b0;
    check("post_sel",  64'(s_sel), 64'h2);
    check("post_addr", 64'(s_addr), 64'h08);
    tick();
    check("post_ready", 64'(m_ready), 64'h1);
    check("post_rdata", 64'(m_rdata), 64'hA5A5_0001);
    check("post_err",   64'(m_err), 64'h0);
    tick();
    check("post_idle", 64'(m_busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
